// File: rtl/kernel_rd_seq.sv
// Kernel memory read sequencer: programs a read window, then pops it rep times
// into a valid/ready kernel stream tagged with per-pass and final-word markers.
module kernel_rd_seq #(
  parameter int GROUP_NB   = 4,
  parameter int KER_WIDTH  = 16,
  parameter int MEM_AWIDTH = 16,
  parameter int MEM_DEPTH  = 1 << MEM_AWIDTH,
  parameter int REP_WIDTH  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [MEM_AWIDTH-1:0]           cmd_start,
  input  logic [MEM_AWIDTH-1:0]           cmd_end,
  input  logic [REP_WIDTH-1:0]            cmd_rep,
  input  logic                            cmd_val,
  output logic                            cmd_rdy,
  output logic                            busy,
  output logic [MEM_AWIDTH-1:0]           rd_cfg_start,
  output logic [MEM_AWIDTH-1:0]           rd_cfg_end,
  output logic                            rd_cfg_set,
  input  logic [GROUP_NB*KER_WIDTH-1:0]   rd_data,
  output logic                            rd_data_pop,
  output logic [GROUP_NB*KER_WIDTH-1:0]   ker_data,
  output logic                            ker_val,
  input  logic                            ker_rdy,
  output logic                            ker_pass_last,
  output logic                            ker_last
);

  typedef enum logic [1:0] {IDLE, CFG, RUN} state_t;

  localparam logic [MEM_AWIDTH:0]  ONE_W = 1;
  localparam logic [REP_WIDTH-1:0] ONE_R = 1;

  state_t                state, state_nxt;
  logic [MEM_AWIDTH:0]   span;
  logic [MEM_AWIDTH:0]   len_nxt;
  logic [MEM_AWIDTH:0]   len;
  logic [MEM_AWIDTH:0]   word_cnt;
  logic [REP_WIDTH-1:0]  rep;
  logic [REP_WIDTH-1:0]  pass_cnt;
  logic                  pass_end;
  logic                  last_pass;

  // Window length modulo memory depth, so start>end wraps through address 0.
  assign span      = (MEM_AWIDTH+1)'(MEM_DEPTH) + {1'b0, cmd_end} - {1'b0, cmd_start};
  assign len_nxt   = {1'b0, span[MEM_AWIDTH-1:0]} + ONE_W;
  assign pass_end  = (word_cnt == len - ONE_W);
  assign last_pass = (pass_cnt == rep - ONE_R);
  assign ker_data  = rd_data;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    cmd_rdy     = 1'b0;
    busy        = 1'b1;
    rd_cfg_set  = 1'b0;
    rd_data_pop = 1'b0;
    case (state)
      IDLE: begin
        cmd_rdy = 1'b1;
        busy    = 1'b0;
        if (cmd_val && (cmd_rep != '0)) state_nxt = CFG;
      end
      CFG: begin
        rd_cfg_set = 1'b1;
        state_nxt  = RUN;
      end
      RUN: begin
        rd_data_pop = ~ker_val | ker_rdy;
        if (rd_data_pop && pass_end && last_pass) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cfg_start  <= '0;
      rd_cfg_end    <= '0;
      rep           <= '0;
      len           <= '0;
      word_cnt      <= '0;
      pass_cnt      <= '0;
      ker_val       <= 1'b0;
      ker_pass_last <= 1'b0;
      ker_last      <= 1'b0;
    end else begin
      if ((state == IDLE) && cmd_val) begin
        rd_cfg_start <= cmd_start;
        rd_cfg_end   <= cmd_end;
        rep          <= cmd_rep;
        len          <= len_nxt;
        word_cnt     <= '0;
        pass_cnt     <= '0;
      end
      // Output flags travel with the popped word and hold while it stalls.
      if (rd_data_pop) begin
        if (pass_end) begin
          word_cnt <= '0;
          pass_cnt <= pass_cnt + ONE_R;
        end else begin
          word_cnt <= word_cnt + ONE_W;
        end
        ker_val       <= 1'b1;
        ker_pass_last <= pass_end;
        ker_last      <= pass_end & last_pass;
      end else if (ker_rdy) begin
        ker_val       <= 1'b0;
        ker_pass_last <= 1'b0;
        ker_last      <= 1'b0;
      end
    end
  end

endmodule
